// File: rtl/priority_encoder_8x3_seq.sv
// -----------------------------------------------------------------------------
// priority_encoder_8x3_seq
//
// Sequential N-to-IDXW priority encoder with a valid/ready output slot. It is
// the return path for the 3x8 decoder. Request pulses on the N lines are
// collected into a sticky pending set. The set is drained one line at a time,
// highest index first, into a single-entry output register. That register is
// presented as a binary line number to a downstream consumer.
//
// Parameters
//   N     number of request lines
//   IDXW  index width; must equal $clog2(N)
//
// Ports
//   clk        in   1     single clock, rising edge
//   rst        in   1     asynchronous, active-high reset
//   en         in   1     request capture enable (0 = req ignored, drain goes on)
//   req        in   N     request pulses; bit i set = event on line i
//   out_valid  out  1     idx holds an undelivered request
//   out_ready  in   1     consumer accepts idx when out_valid & out_ready
//   idx        out  IDXW  encoded line number of the delivered request
//   pending    out  N     requests captured but not yet loaded into the slot
//   any        out  1     |pending | out_valid
//   overflow   out  1     one-cycle pulse: a request merged into a pending bit
// -----------------------------------------------------------------------------
module priority_encoder_8x3_seq #(
  parameter int N    = 8,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] idx,
  output logic [N-1:0]    pending,
  output logic            any,
  output logic            overflow
);

  // Index of the highest set bit of vec. The scan runs upward, so a later
  // (higher) set bit overrides an earlier one. An all-zero vector returns 0.
  // The caller never uses that value, because a load needs pending != 0.
  function automatic logic [IDXW-1:0] highest_set(input logic [N-1:0] vec);
    logic [IDXW-1:0] sel;
    sel = {IDXW{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        sel = IDXW'(i);
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  // One-hot decode of an index into an N-bit vector.
  function automatic logic [N-1:0] one_hot(input logic [IDXW-1:0] sel);
    logic [N-1:0] vec;
    vec = {{(N-1){1'b0}}, 1'b1} << sel;
    return vec;
  endfunction

  logic [N-1:0]    pending_r;
  logic            out_valid_r;
  logic [IDXW-1:0] idx_r;
  logic            overflow_r;

  logic [N-1:0]    set_vec_s;
  logic [N-1:0]    clr_vec_s;
  logic            slot_free_s;
  logic            pending_nz_s;
  logic            load_s;
  logic [IDXW-1:0] sel_s;

  // Next-state terms. The slot counts as free in the same cycle the consumer
  // takes the current index, so back-to-back delivery is possible.
  always_comb begin
    set_vec_s    = req & {N{en}};
    slot_free_s  = ~out_valid_r | out_ready;
    pending_nz_s = |pending_r;
    load_s       = slot_free_s & pending_nz_s;
    sel_s        = highest_set(pending_r);
    if (load_s) begin
      clr_vec_s = one_hot(sel_s);
    end else begin
      clr_vec_s = {N{1'b0}};
    end
  end

  // Pending set, output slot and overflow pulse. In the pending update, set
  // is ORed in after the clear. A new request on the line being loaded
  // therefore stays pending as a fresh event. It does not count as overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r   <= {N{1'b0}};
      out_valid_r <= 1'b0;
      idx_r       <= {IDXW{1'b0}};
      overflow_r  <= 1'b0;
    end else begin
      pending_r  <= (pending_r & ~clr_vec_s) | set_vec_s;
      overflow_r <= |(set_vec_s & pending_r & ~clr_vec_s);
      if (load_s) begin
        idx_r       <= sel_s;
        out_valid_r <= 1'b1;
      end else if (slot_free_s) begin
        // Nothing to load. The slot empties, and idx keeps its last value.
        idx_r       <= idx_r;
        out_valid_r <= 1'b0;
      end else begin
        // Backpressure: hold the undelivered index stable.
        idx_r       <= idx_r;
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign pending   = pending_r;
  assign out_valid = out_valid_r;
  assign idx       = idx_r;
  assign overflow  = overflow_r;
  assign any       = (|pending_r) | out_valid_r;

endmodule
